// File: rtl/uart_cmd_resp.sv
// UART responder: 8N1 receive with 3-byte command packet assembly,
// plus a single-byte response transmitter. RX and TX run independently.
module uart_cmd_resp #(
    parameter int BAUD_CNT     = 2604,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        frm_err,
    output logic        pkt_err
);

    localparam int CW     = $clog2(BAUD_CNT + 1);
    localparam int TO_LIM = TIMEOUT_BITS * BAUD_CNT;
    localparam int TW     = $clog2(TO_LIM + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_st_t;

    typedef enum logic [1:0] {
        A_CMD,
        A_HI,
        A_LO
    } asm_st_t;

    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_prev;
    rx_st_t        r_rx_st;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic          r_frm_err;

    asm_st_t       r_asm_st;
    logic [7:0]    r_cmd_sh;
    logic [7:0]    r_hi;
    logic [7:0]    r_cmd;
    logic [15:0]   r_data;
    logic          r_cmd_rdy;
    logic [TW-1:0] r_to_cnt;
    logic          r_pkt_err;

    logic          r_tx;
    logic          r_tx_busy;
    logic          r_resp_sent;
    logic [8:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;

    logic w_rx_fall;
    logic w_rx_tick;
    logic w_byte_vld;
    logic w_to_run;

    assign w_rx_fall  = r_rx_prev & ~r_rx_s2;
    assign w_rx_tick  = (r_rx_cnt == CW'(1));
    assign w_byte_vld = (r_rx_st == RX_STOP) & w_rx_tick & r_rx_s2;
    assign w_to_run   = (r_asm_st != A_CMD) & (r_rx_st == RX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_frm_err <= 1'b0;
        end else begin
            r_rx_s1   <= RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_frm_err <= 1'b0;
            case (r_rx_st)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_st  <= RX_START;
                        r_rx_cnt <= CW'(BAUD_CNT / 2);
                    end
                end
                RX_START: begin
                    if (!w_rx_tick) begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end else if (r_rx_s2) begin
                        r_rx_st  <= RX_IDLE;
                        r_rx_cnt <= '0;
                    end else begin
                        r_rx_st  <= RX_DATA;
                        r_rx_cnt <= CW'(BAUD_CNT);
                        r_rx_bit <= '0;
                    end
                end
                RX_DATA: begin
                    if (!w_rx_tick) begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end else begin
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        r_rx_cnt <= CW'(BAUD_CNT);
                        if (r_rx_bit == 3'd7) begin
                            r_rx_st <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (!w_rx_tick) begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end else begin
                        r_rx_st   <= RX_IDLE;
                        r_rx_cnt  <= '0;
                        r_frm_err <= ~r_rx_s2;
                    end
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

    // Timeout only advances while the line is idle between bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm_st  <= A_CMD;
            r_cmd_sh  <= '0;
            r_hi      <= '0;
            r_cmd     <= '0;
            r_data    <= '0;
            r_cmd_rdy <= 1'b0;
            r_to_cnt  <= '0;
            r_pkt_err <= 1'b0;
        end else begin
            r_pkt_err <= 1'b0;
            if (w_byte_vld) begin
                r_to_cnt <= '0;
                case (r_asm_st)
                    A_CMD: begin
                        r_cmd_sh <= r_rx_sh;
                        r_asm_st <= A_HI;
                    end
                    A_HI: begin
                        r_hi     <= r_rx_sh;
                        r_asm_st <= A_LO;
                    end
                    default: begin
                        r_cmd    <= r_cmd_sh;
                        r_data   <= {r_hi, r_rx_sh};
                        r_asm_st <= A_CMD;
                    end
                endcase
            end else if (w_to_run) begin
                if (r_to_cnt == TW'(TO_LIM - 1)) begin
                    r_pkt_err <= 1'b1;
                    r_asm_st  <= A_CMD;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else if (r_asm_st == A_CMD) begin
                r_to_cnt <= '0;
            end

            if (w_byte_vld && r_asm_st == A_LO) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || (w_byte_vld && r_asm_st == A_CMD)) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx        <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_resp_sent <= 1'b0;
            r_tx_sh     <= '1;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
        end else begin
            r_resp_sent <= 1'b0;
            if (!r_tx_busy) begin
                if (send_resp) begin
                    r_tx_busy <= 1'b1;
                    r_tx      <= 1'b0;
                    r_tx_sh   <= {1'b1, resp};
                    r_tx_cnt  <= CW'(BAUD_CNT - 1);
                    r_tx_bit  <= '0;
                end
            end else if (r_tx_cnt != '0) begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end else if (r_tx_bit == 4'd9) begin
                r_tx_busy   <= 1'b0;
                r_resp_sent <= 1'b1;
                r_tx        <= 1'b1;
            end else begin
                r_tx     <= r_tx_sh[0];
                r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
                r_tx_cnt <= CW'(BAUD_CNT - 1);
                r_tx_bit <= r_tx_bit + 1'b1;
            end
        end
    end

    assign TX        = r_tx;
    assign cmd       = r_cmd;
    assign data      = r_data;
    assign cmd_rdy   = r_cmd_rdy;
    assign tx_busy   = r_tx_busy;
    assign resp_sent = r_resp_sent;
    assign frm_err   = r_frm_err;
    assign pkt_err   = r_pkt_err;

endmodule

// File: tb/tb_uart_cmd_resp.sv
// Scoreboard bench for uart_cmd_resp: packet/response expectations queued
// by the stimulus, compared by independent monitors.
module tb_uart_cmd_resp;

    localparam int BAUD = 16;
    localparam int TOB  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;
    logic        frm_err;
    logic        pkt_err;

    always #5 clk = ~clk;

    uart_cmd_resp #(.BAUD_CNT(BAUD), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX),
        .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .tx_busy(tx_busy), .resp_sent(resp_sent),
        .frm_err(frm_err), .pkt_err(pkt_err)
    );

    typedef struct packed {
        logic [7:0]  c;
        logic [15:0] d;
    } pkt_t;

    int         n_vec = 0;
    int         n_bad = 0;
    pkt_t       exp_pkt[$];
    logic [7:0] part[$];
    logic [9:0] exp_frm[$];
    int         exp_frmerr = 0;
    int         exp_pkterr = 0;
    int         got_frmerr = 0;
    int         got_pkterr = 0;
    longint     cyc = 0;
    longint     tx_free = 0;
    bit         abort_rx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: packets are just every third good byte
    function automatic void mdl_byte(input logic [7:0] b);
        pkt_t p;
        part.push_back(b);
        if (part.size() == 3) begin
            p.c = part[0];
            p.d = {part[1], part[2]};
            exp_pkt.push_back(p);
            part.delete();
        end
    endfunction

    function automatic void mdl_timeout();
        part.delete();
        exp_pkterr++;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1,
                             input bit mdl = 1'b1);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        if (mdl) begin
            if (stop_ok) mdl_byte(b);
            else exp_frmerr++;
        end
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            for (int j = 0; j < BAUD; j++) begin
                @(negedge clk);
                if (abort_rx) begin
                    RX = 1'b1;
                    return;
                end
            end
        end
        RX = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BAUD) @(negedge clk);
    endtask

    task automatic drive_resp(input logic [7:0] v);
        longint c;
        resp      = v;
        send_resp = 1'b1;
        c = cyc + 1;
        if (c >= tx_free) begin
            exp_frm.push_back({1'b1, v, 1'b0});
            tx_free = c + 161;
        end
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic issue_resp(input logic [7:0] v);
        @(negedge clk);
        drive_resp(v);
    endtask

    task automatic wait_sent(input string nm, input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (resp_sent) seen = 1'b1;
        end
        chk(nm, {31'd0, seen}, 32'd1);
    endtask

    bit prev_rdy = 1'b0;
    always @(negedge clk) begin : mon_rx
        pkt_t p;
        if (rst) begin
            prev_rdy = 1'b0;
        end else begin
            if (cmd_rdy && !prev_rdy) begin
                if (exp_pkt.size() == 0) begin
                    chk("unexpected_pkt", {8'd0, cmd, data}, 32'hFFFFFFFF);
                end else begin
                    p = exp_pkt.pop_front();
                    chk("cmd", {24'd0, cmd}, {24'd0, p.c});
                    chk("data", {16'd0, data}, {16'd0, p.d});
                end
            end
            prev_rdy = cmd_rdy;
            if (frm_err) got_frmerr++;
            if (pkt_err) got_pkterr++;
        end
    end

    bit         tx_act = 1'b0;
    int         tk = 0;
    logic [9:0] got_frm;
    always @(negedge clk) begin : mon_tx
        logic [9:0] e;
        if (rst) begin
            if (tx_act && exp_frm.size() > 0) void'(exp_frm.pop_front());
            tx_act = 1'b0;
        end else begin
            if (!tx_act && tx_busy) begin
                tx_act = 1'b1;
                tk = 0;
                chk("tx_start_align", {31'd0, TX}, 32'd0);
            end
            if (tx_act) begin
                if (tk < 160) begin
                    if (tk % 16 == 8) begin
                        got_frm[tk/16] = TX;
                        chk("tx_busy_hold", {31'd0, tx_busy}, 32'd1);
                    end
                end else begin
                    chk("resp_sent_time", {31'd0, resp_sent}, 32'd1);
                    chk("tx_busy_end", {31'd0, tx_busy}, 32'd0);
                    if (exp_frm.size() == 0) begin
                        chk("unexpected_frame", {22'd0, got_frm}, 32'hFFFFFFFF);
                    end else begin
                        e = exp_frm.pop_front();
                        chk("tx_frame", {22'd0, got_frm}, {22'd0, e});
                    end
                    tx_act = 1'b0;
                end
                tk++;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; resp = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_TX", {31'd0, TX}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("rst_cmd", {24'd0, cmd}, 32'd0);
        chk("rst_data", {16'd0, data}, 32'd0);
        chk("rst_pulses", {29'd0, resp_sent, frm_err, pkt_err}, 32'd0);
        rst = 1'b0;
        idle_bits(2);

        send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
        idle_bits(1);
        chk("rdy_set", {31'd0, cmd_rdy}, 32'd1);
        send_byte(8'h3C);
        chk("rdy_clr_by_byte", {31'd0, cmd_rdy}, 32'd0);
        send_byte(8'h55); send_byte(8'hAA);
        idle_bits(1);
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        chk("rdy_clr", {31'd0, cmd_rdy}, 32'd0);
        chk("cmd_hold", {24'd0, cmd}, 32'h3C);
        chk("data_hold", {16'd0, data}, 32'h55AA);

        send_byte(8'hA5); send_byte(8'hFF);
        clr_cmd_rdy = 1'b1;
        send_byte(8'h00);
        idle_bits(1);
        clr_cmd_rdy = 1'b0;
        chk("pkt_q_setwins", exp_pkt.size(), 0);
        chk("cmd_A5", {24'd0, cmd}, 32'hA5);

        send_byte(8'h07); send_byte(8'h88);
        mdl_timeout();
        idle_bits(33);
        chk("pkt_err_cnt", got_pkterr, exp_pkterr);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        idle_bits(2);

        send_byte(8'h11);
        send_byte(8'h22, 1'b0);
        idle_bits(1);
        send_byte(8'h33); send_byte(8'h44);
        idle_bits(2);
        chk("frm_err_cnt", got_frmerr, exp_frmerr);
        @(negedge clk); RX = 1'b0;
        repeat (6) @(negedge clk);
        RX = 1'b1;
        idle_bits(3);
        chk("glitch_frm", got_frmerr, exp_frmerr);
        send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C);
        idle_bits(2);
        chk("pkt_q_glitch", exp_pkt.size(), 0);

        issue_resp(8'hA5);
        repeat (48) @(negedge clk);
        drive_resp(8'h3C);
        chk("busy_mid", {31'd0, tx_busy}, 32'd1);
        wait_sent("sent_1", 300);
        drive_resp(8'h96);
        wait_sent("sent_b2b", 300);
        idle_bits(2);

        fork
            begin
                for (int p = 0; p < 20; p++) begin
                    for (int j = 0; j < 3; j++) begin
                        if ($urandom_range(0, 7) == 0) begin
                            send_byte(8'($urandom), 1'b0);
                            idle_bits(1);
                        end
                        b = 8'($urandom);
                        send_byte(b);
                        idle_bits($urandom_range(0, 6));
                    end
                end
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    repeat ($urandom_range(10, 250)) @(negedge clk);
                    issue_resp(8'($urandom));
                end
            end
        join
        idle_bits(12);
        chk("rand_frm_err", got_frmerr, exp_frmerr);
        chk("rand_pkt_err", got_pkterr, exp_pkterr);
        chk("pre_rst_rdy", {31'd0, cmd_rdy}, 32'd1);

        fork
            send_byte(8'h10, 1'b1, 1'b0);
            begin
                issue_resp(8'h77);
                repeat (84) @(negedge clk);
                abort_rx = 1'b1;
                @(negedge clk); rst = 1'b1;
                @(negedge clk); rst = 1'b0;
                chk("mid_rst_TX", {31'd0, TX}, 32'd1);
                chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
                chk("mid_rst_rdy", {31'd0, cmd_rdy}, 32'd0);
                chk("mid_rst_cmd", {8'd0, cmd, data}, 32'd0);
            end
        join
        abort_rx = 1'b0;
        part.delete();
        tx_free = 0;
        idle_bits(2);
        send_byte(8'h10); send_byte(8'hBE); send_byte(8'hEF);
        idle_bits(12);
        chk("cmd_10", {24'd0, cmd}, 32'h10);
        chk("data_BEEF", {16'd0, data}, 32'hBEEF);
        chk("end_pkt_q", exp_pkt.size(), 0);
        chk("end_frm_q", exp_frm.size(), 0);
        chk("end_frm_err", got_frmerr, exp_frmerr);
        chk("end_pkt_err", got_pkterr, exp_pkterr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
